// File: rtl/tx_pkg.sv
// Shared types and Ethernet/XGMII constants for the TX frame sequencer.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        CRC,
        IFG
    } tx_state_t;

    localparam int ETH_MIN_FRAME = 60;
    localparam int ETH_MAX_FRAME = 1514;
    localparam int ETH_FCS_BYTES = 4;
    localparam int XGMII_BYTES   = 8;

endpackage

// File: rtl/tx_ifg_timer.sv
// Loadable down-counter timing the inter-frame gap; done is high on the final gap cycle.
module tx_ifg_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (enable && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt <= WIDTH'(1));

endmodule

// File: rtl/tx_frame_ctrl.sv
// TX frame sequencer: counts client bytes per frame, pads short frames,
// strobes FCS insertion and holds off the client for the inter-frame gap.
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME,
    parameter int IFG_BYTES       = 12,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic                 tx_valid,
    input  logic                 tx_last,
    input  logic [2:0]           tx_last_bytes,
    output logic                 tx_ready,
    output logic [3:0]           pad_cnt,
    output logic                 crc_insert,
    output logic                 ifg_active,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 len_valid,
    output logic                 oversize_err,
    output logic [31:0]          frame_count
);

    localparam int IFG_CYCLES = (IFG_BYTES + XGMII_BYTES - 1) / XGMII_BYTES;
    localparam int IFG_W      = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);

    localparam logic [LEN_WIDTH-1:0] MIN_LEN  = LEN_WIDTH'(MIN_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] FCS_LEN  = LEN_WIDTH'(ETH_FCS_BYTES);
    localparam logic [LEN_WIDTH-1:0] WORD_LEN = LEN_WIDTH'(XGMII_BYTES);

    // Byte counts pin at all-ones instead of wrapping so oversize stays visible.
    function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [LEN_WIDTH-1:0] a,
                                                     input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_WIDTH] ? '1 : s[LEN_WIDTH-1:0];
    endfunction

    tx_state_t state, state_next;

    logic [LEN_WIDTH-1:0] byte_cnt, byte_cnt_next;
    logic [LEN_WIDTH-1:0] pad_rem, pad_rem_next;
    logic                 first_pad, first_pad_next;

    logic [LEN_WIDTH-1:0] last_add, base_len, word_sum;
    logic [LEN_WIDTH-1:0] pad_cap, pad_amt, padded_len;
    logic                 timer_load, timer_en, ifg_done;

    always_comb begin
        last_add   = (tx_last_bytes == 3'd0) ? WORD_LEN : LEN_WIDTH'(tx_last_bytes);
        base_len   = (state == DATA) ? byte_cnt : '0;
        word_sum   = sat_add(base_len, tx_last ? last_add : WORD_LEN);
        // The first pad beat only fills what is left of the partial last word.
        pad_cap    = (first_pad && byte_cnt[2:0] != 3'd0)
                   ? WORD_LEN - LEN_WIDTH'(byte_cnt[2:0]) : WORD_LEN;
        pad_amt    = (pad_rem < pad_cap) ? pad_rem : pad_cap;
        padded_len = sat_add((byte_cnt < MIN_LEN) ? MIN_LEN : byte_cnt, FCS_LEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        byte_cnt_next  = byte_cnt;
        pad_rem_next   = pad_rem;
        first_pad_next = first_pad;
        tx_ready       = 1'b0;
        pad_cnt        = 4'd0;
        crc_insert     = 1'b0;
        len_valid      = 1'b0;
        oversize_err   = 1'b0;
        frame_len      = '0;
        ifg_active     = 1'b0;
        timer_load     = 1'b0;
        timer_en       = 1'b0;

        case (state)
            IDLE, DATA: begin
                tx_ready = 1'b1;
                if (tx_valid && (tx_start || state == DATA)) begin
                    byte_cnt_next = word_sum;
                    if (tx_last) begin
                        if (word_sum < MIN_LEN) begin
                            state_next     = PAD;
                            pad_rem_next   = MIN_LEN - word_sum;
                            first_pad_next = 1'b1;
                        end else begin
                            state_next = CRC;
                        end
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            PAD: begin
                pad_cnt        = pad_amt[3:0];
                pad_rem_next   = pad_rem - pad_amt;
                first_pad_next = 1'b0;
                if (pad_rem == pad_amt) begin
                    state_next = CRC;
                end
            end
            CRC: begin
                crc_insert   = 1'b1;
                len_valid    = 1'b1;
                frame_len    = padded_len;
                oversize_err = (byte_cnt > MAX_LEN);
                timer_load   = 1'b1;
                state_next   = (IFG_CYCLES == 0) ? IDLE : IFG;
            end
            IFG: begin
                ifg_active = 1'b1;
                timer_en   = 1'b1;
                if (ifg_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= '0;
            pad_rem     <= '0;
            first_pad   <= 1'b0;
            frame_count <= '0;
        end else begin
            byte_cnt  <= byte_cnt_next;
            pad_rem   <= pad_rem_next;
            first_pad <= first_pad_next;
            if (state == CRC) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

    tx_ifg_timer #(
        .WIDTH (IFG_W)
    ) u_ifg_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (IFG_W'(IFG_CYCLES)),
        .enable     (timer_en),
        .done       (ifg_done)
    );

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: directed frames push expected pad beats
// and frame results; a negedge monitor pops and compares them.
module tb_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_start, tx_valid, tx_last;
    logic [2:0]  tx_last_bytes;
    logic        tx_ready;
    logic [3:0]  pad_cnt;
    logic        crc_insert, ifg_active, len_valid, oversize_err;
    logic [15:0] frame_len;
    logic [31:0] frame_count;

    tx_frame_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .tx_start      (tx_start),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_last_bytes (tx_last_bytes),
        .tx_ready      (tx_ready),
        .pad_cnt       (pad_cnt),
        .crc_insert    (crc_insert),
        .ifg_active    (ifg_active),
        .frame_len     (frame_len),
        .len_valid     (len_valid),
        .oversize_err  (oversize_err),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = pad beat, kind 1 = frame completion
    typedef struct {
        int kind;
        int value;
        int ovf;
        int cyc;
        int fcount;
    } exp_t;

    exp_t expq[$];
    int   pad_plan[$];
    int   exp_frames = 0;
    int   compares   = 0;
    int   failures   = 0;
    bit   watch_ifg  = 1'b0;
    int   ifg_run    = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compares++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit v, input bit l, input logic [2:0] lb);
        @(posedge clk);
        #1;
        tx_start      = s;
        tx_valid      = v;
        tx_last       = l;
        tx_last_bytes = lb;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tx_ready) checkOutput("ready_timeout", 0, 1);
    endtask

    // track: 0 = expect nothing, 1 = pads and frame, 2 = pads only (aborted)
    task automatic sendFrame(input int nwords, input logic [2:0] lb, input int flen,
                             input int ovf, input bit gap, input bit stray, input int track);
        int   last_cyc;
        bit   is_last;
        exp_t e;
        waitReady();
        for (int i = 0; i < nwords; i++) begin
            is_last = (i == nwords - 1);
            if (gap && i == 1) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
            applyStimulus((i == 0) || (stray && i == 1), 1'b1, is_last, is_last ? lb : 3'd3);
        end
        last_cyc = cyc;
        if (track >= 1) begin
            for (int i = 0; i < pad_plan.size(); i++) begin
                e = '{0, pad_plan[i], 0, last_cyc + 1 + i, 0};
                expq.push_back(e);
            end
        end
        if (track == 1) begin
            e = '{1, flen, ovf, last_cyc + 1 + pad_plan.size(), exp_frames};
            expq.push_back(e);
            exp_frames++;
        end
        pad_plan.delete();
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (!reset) begin
            if (pad_cnt != 4'd0) begin
                if (expq.size() == 0 || expq[0].kind != 0) begin
                    checkOutput("unexpected_pad", pad_cnt, 0);
                end else begin
                    m = expq.pop_front();
                    checkOutput("pad_cnt", pad_cnt, m.value);
                    checkOutput("pad_cycle", cyc, m.cyc);
                    checkOutput("pad_ready", tx_ready, 0);
                end
            end
            if (len_valid || crc_insert || oversize_err) begin
                if (expq.size() == 0 || expq[0].kind != 1) begin
                    checkOutput("unexpected_frame", 1, 0);
                end else begin
                    m = expq.pop_front();
                    checkOutput("frame_len", frame_len, m.value);
                    checkOutput("oversize_err", oversize_err, m.ovf);
                    checkOutput("crc_insert", crc_insert, 1);
                    checkOutput("len_valid", len_valid, 1);
                    checkOutput("crc_cycle", cyc, m.cyc);
                    checkOutput("frame_count_at_crc", frame_count, m.fcount);
                    checkOutput("crc_ready", tx_ready, 0);
                end
                watch_ifg = 1'b1;
                ifg_run   = 0;
            end else if (watch_ifg) begin
                if (ifg_active) begin
                    ifg_run++;
                end else begin
                    checkOutput("ifg_cycles", ifg_run, 2);
                    watch_ifg = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset         = 1'b1;
        tx_start      = 1'b0;
        tx_valid      = 1'b0;
        tx_last       = 1'b0;
        tx_last_bytes = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_pad_cnt", pad_cnt, 0);
        checkOutput("rst_crc_insert", crc_insert, 0);
        checkOutput("rst_ifg_active", ifg_active, 0);
        checkOutput("rst_frame_len", frame_len, 0);
        checkOutput("rst_len_valid", len_valid, 0);
        checkOutput("rst_oversize", oversize_err, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] tx_valid without tx_start in IDLE");
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd2);
        idleCycles(1);
        checkOutput("idle_ignore_ready", tx_ready, 1);

        $display("[TB] 64-byte frame");
        sendFrame(8, 3'd0, 68, 0, 1'b0, 1'b0, 1);
        idleCycles(4);
        checkOutput("frame_count_1", frame_count, 1);

        $display("[TB] 17-byte frame with gap and stray start");
        pad_plan = '{7, 8, 8, 8, 8, 4};
        sendFrame(3, 3'd1, 64, 0, 1'b1, 1'b1, 1);
        idleCycles(1);

        $display("[TB] single-word 3-byte frame");
        pad_plan = '{5, 8, 8, 8, 8, 8, 8, 4};
        sendFrame(1, 3'd3, 64, 0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
            checkOutput("ready_busy", tx_ready, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("ready_after_ifg", tx_ready, 1);

        $display("[TB] exactly-minimum 60-byte frame");
        sendFrame(8, 3'd4, 64, 0, 1'b0, 1'b0, 1);
        idleCycles(1);

        $display("[TB] exactly-maximum 1514-byte frame");
        sendFrame(190, 3'd2, 1518, 0, 1'b0, 1'b0, 1);
        idleCycles(1);

        $display("[TB] oversize 1520-byte frame");
        sendFrame(190, 3'd0, 1524, 1, 1'b0, 1'b0, 1);
        idleCycles(1);

        $display("[TB] back-to-back start during CRC/IFG");
        sendFrame(8, 3'd0, 68, 0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd3);
            checkOutput("b2b_ready_low", tx_ready, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("b2b_ready_idle", tx_ready, 1);
        pad_plan = '{8, 8, 8, 8, 8, 4};
        sendFrame(2, 3'd0, 64, 0, 1'b0, 1'b0, 1);
        idleCycles(1);

        $display("[TB] reset during PAD");
        pad_plan = '{7, 8};
        sendFrame(1, 3'd1, 0, 0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_tx_ready", tx_ready, 1);
        checkOutput("abort_pad_cnt", pad_cnt, 0);
        checkOutput("abort_crc_insert", crc_insert, 0);
        checkOutput("abort_frame_count", frame_count, 0);
        exp_frames = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(12);
        checkOutput("abort_no_frame", frame_count, 0);

        $display("[TB] frame after reset");
        sendFrame(8, 3'd4, 64, 0, 1'b0, 1'b0, 1);
        idleCycles(4);
        checkOutput("frame_count_after_reset", frame_count, 1);

        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
        $finish;
    end

endmodule
